chan_mux_scan: RTL and testbench



---
 rtl/chan_mux_scan.sv | 110 +++++++++++
 tb/tb_chan_mux_scan.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/chan_mux_scan.sv
// chan_mux_scan: registered N:1 channel mux with a valid/ready output stage,
// direct-select and round-robin scan modes. Define RR_SKIP_EN for skip-idle scan.
module chan_mux_scan #(
  parameter int W = 4,
  parameter int N = 8,
  localparam int SW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N*W-1:0] w_i,
  input  logic [N-1:0]   req_i,
  input  logic           mode_i,
  input  logic [SW-1:0]  sel_i,
  output logic [W-1:0]   f_o,
  output logic [SW-1:0]  out_ch_o,
  output logic           out_valid_o,
  input  logic           out_ready_i
);
  localparam int NP = 1 << SW;

  logic [W-1:0]  f_q, f_d;
  logic [SW-1:0] ch_q, ch_d;
  logic [SW-1:0] ptr_q, ptr_d;
  logic          vld_q, vld_d;

  logic [NP-1:0] req_pad;
  logic          load;
  logic          hit;
  logic [SW-1:0] cand;
  logic [SW-1:0] cand_inc;
  logic [W-1:0]  cand_data;

  // Padding to a power of two makes indices >= N read as "no request".
  assign req_pad = NP'(req_i);
  assign load    = !vld_q || out_ready_i;

  always_comb begin
    int p;
    hit  = 1'b0;
    cand = ptr_q;
    p    = 0;
    if (!mode_i) begin
      hit  = req_pad[sel_i];
      cand = sel_i;
    end else begin
`ifdef RR_SKIP_EN
      // Walk from the farthest offset to the nearest so the nearest eligible index wins.
      for (int i = N - 1; i >= 0; i--) begin
        p = int'(ptr_q) + i;
        if (p >= N) p = p - N;
        if (req_pad[SW'(p)]) begin
          hit  = 1'b1;
          cand = SW'(p);
        end
      end
`else
      hit  = req_pad[ptr_q];
      cand = ptr_q;
`endif
    end
  end

  always_comb begin
    cand_data = '0;
    for (int c = 0; c < N; c++) begin
      if (cand == SW'(c)) cand_data = w_i[c*W +: W];
    end
    cand_inc = (cand == SW'(N - 1)) ? '0 : cand + 1'b1;
  end

  always_comb begin
    f_d   = f_q;
    ch_d  = ch_q;
    vld_d = vld_q;
    ptr_d = ptr_q;
    if (load) begin
      vld_d = hit;
      if (hit) begin
        f_d  = cand_data;
        ch_d = cand;
      end
      if (mode_i) begin
`ifdef RR_SKIP_EN
        if (hit) ptr_d = cand_inc;
`else
        ptr_d = cand_inc;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      f_q   <= '0;
      ch_q  <= '0;
      vld_q <= 1'b0;
      ptr_q <= '0;
    end else begin
      f_q   <= f_d;
      ch_q  <= ch_d;
      vld_q <= vld_d;
      ptr_q <= ptr_d;
    end
  end

  assign f_o         = f_q;
  assign out_ch_o    = ch_q;
  assign out_valid_o = vld_q;

endmodule

// File: tb/tb_chan_mux_scan.sv
// Bench for chan_mux_scan: directed vector table, hand-written corner sequences,
// and randomized traffic against a behavioural model on N=8 and N=6 instances.
`timescale 1ns/1ps
module tb_chan_mux_scan;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] w;
  logic [7:0]  req;
  logic        mode;
  logic [2:0]  sel;
  logic        rdy;
  logic [3:0]  f8, f6;
  logic [2:0]  ch8, ch6;
  logic        v8, v6;

  int checks = 0;
  int errors = 0;

  chan_mux_scan #(.W(4), .N(8)) dut8 (
    .clk(clk), .rst(rst), .w_i(w), .req_i(req), .mode_i(mode), .sel_i(sel),
    .f_o(f8), .out_ch_o(ch8), .out_valid_o(v8), .out_ready_i(rdy));

  chan_mux_scan #(.W(4), .N(6)) dut6 (
    .clk(clk), .rst(rst), .w_i(w[23:0]), .req_i(req[5:0]), .mode_i(mode), .sel_i(sel),
    .f_o(f6), .out_ch_o(ch6), .out_valid_o(v6), .out_ready_i(rdy));

  always #5 clk = ~clk;

  typedef struct {
    bit          rst;
    bit          mode;
    logic [2:0]  sel;
    logic [7:0]  req;
    logic [31:0] w;
    bit          rdy;
    logic [3:0]  ef;
    logic [2:0]  ech;
    bit          ev;
  } vec_t;
  vec_t tbl[$];

  typedef struct { int f; int ch; int vld; int ptr; } mstate_t;

  function automatic void add(bit r, bit md, logic [2:0] sl, logic [7:0] rq, logic [31:0] wd,
                              bit rd, logic [3:0] ef, logic [2:0] ech, bit ev);
    vec_t v;
    v.rst = r; v.mode = md; v.sel = sl; v.req = rq; v.w = wd; v.rdy = rd;
    v.ef = ef; v.ech = ech; v.ev = ev;
    tbl.push_back(v);
  endfunction

  // Reference: one clock of the channel selector, from the operating rules.
  function automatic mstate_t step(mstate_t s, int n, bit r, bit md, int sl,
                                   logic [7:0] rq, logic [31:0] wd, bit rd);
    mstate_t nx = s;
    int c;
    bit found;
    if (r) begin
      nx.f = 0; nx.ch = 0; nx.vld = 0; nx.ptr = 0;
      return nx;
    end
    if (s.vld == 1 && !rd) return nx;
    found = 0;
    c = 0;
    if (!md) begin
      if (sl < n && rq[sl]) begin found = 1; c = sl; end
    end else begin
`ifdef RR_SKIP_EN
      for (int k = 0; k < n; k++)
        if (!found && rq[(s.ptr + k) % n]) begin found = 1; c = (s.ptr + k) % n; end
      if (found) nx.ptr = (c + 1) % n;
`else
      c = s.ptr;
      found = rq[c];
      nx.ptr = (s.ptr + 1) % n;
`endif
    end
    if (found) begin
      nx.f = int'((wd >> (4 * c)) & 32'hF);
      nx.ch = c;
      nx.vld = 1;
    end else begin
      nx.vld = 0;
    end
    return nx;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(bit r, bit md, logic [2:0] sl, logic [7:0] rq, logic [31:0] wd, bit rd);
    rst = r; mode = md; sel = sl; req = rq; w = wd; rdy = rd;
  endtask

  localparam logic [31:0] WA = 32'hFEDCBA98;
  localparam logic [31:0] WB = 32'h12345678;

  initial begin
    mstate_t m8, m6;
    bit seen;

    drive(1, 0, 3'd5, 8'hFF, WA, 1);

    // reset, direct, no-request, backpressure
    add(1, 0, 3'd5, 8'hFF, WA, 1, 4'h0, 3'd0, 0);
    add(0, 0, 3'd5, 8'hFF, WA, 1, 4'hD, 3'd5, 1);
    add(0, 0, 3'd5, 8'hDF, WA, 1, 4'hD, 3'd5, 0);
    add(0, 0, 3'd5, 8'hFF, WA, 1, 4'hD, 3'd5, 1);
    add(0, 0, 3'd2, 8'hFF, WB, 0, 4'hD, 3'd5, 1);
    add(0, 0, 3'd3, 8'hFF, WB, 0, 4'hD, 3'd5, 1);
    add(0, 0, 3'd1, 8'hFF, WB, 0, 4'hD, 3'd5, 1);
    add(0, 0, 3'd1, 8'hFF, WB, 1, 4'h7, 3'd1, 1);
    add(0, 0, 3'd0, 8'hFF, WB, 1, 4'h8, 3'd0, 1);
    // scan from reset with req = 1000_0101
    add(1, 1, 3'd0, 8'h85, WA, 1, 4'h0, 3'd0, 0);
`ifdef RR_SKIP_EN
    for (int k = 0; k < 3; k++) begin
      add(0, 1, 3'd0, 8'h85, WA, 1, 4'h8, 3'd0, 1);
      add(0, 1, 3'd0, 8'h85, WA, 1, 4'hA, 3'd2, 1);
      add(0, 1, 3'd0, 8'h85, WA, 1, 4'hF, 3'd7, 1);
    end
`else
    add(0, 1, 3'd0, 8'h85, WA, 1, 4'h8, 3'd0, 1);
    add(0, 1, 3'd0, 8'h85, WA, 1, 4'h8, 3'd0, 0);
    add(0, 1, 3'd0, 8'h85, WA, 1, 4'hA, 3'd2, 1);
    for (int k = 0; k < 4; k++)
      add(0, 1, 3'd0, 8'h85, WA, 1, 4'hA, 3'd2, 0);
    add(0, 1, 3'd0, 8'h85, WA, 1, 4'hF, 3'd7, 1);
    add(0, 1, 3'd0, 8'h85, WA, 1, 4'h8, 3'd0, 1);
`endif

    foreach (tbl[k]) begin
      drive(tbl[k].rst, tbl[k].mode, tbl[k].sel, tbl[k].req, tbl[k].w, tbl[k].rdy);
      tick();
      chk($sformatf("tbl%0d.f", k), 32'(f8), 32'(tbl[k].ef));
      chk($sformatf("tbl%0d.ch", k), 32'(ch8), 32'(tbl[k].ech));
      chk($sformatf("tbl%0d.valid", k), 32'(v8), 32'(tbl[k].ev));
    end

    // out-of-range select on the 6-channel instance
    drive(1, 0, 3'd7, 8'hFF, WA, 1); tick();
    drive(0, 0, 3'd7, 8'hFF, WA, 1); tick();
    chk("oor.valid6", 32'(v6), 32'd0);
    chk("oor.f6", 32'(f6), 32'd0);
    chk("oor.valid8", 32'(v8), 32'd1);
    chk("oor.f8", 32'(f8), 32'hF);

    // stalled scan transfer interrupted by reset; pointer must restart at 0
    drive(1, 1, 3'd0, 8'h85, WA, 1); tick();
    rst = 0;
    seen = 0;
    for (int k = 0; k < 16 && !seen; k++) begin
      tick();
      if (v8 && ch8 == 3'd2) seen = 1;
    end
    chk("stall.reach_ch2", 32'(seen), 32'd1);
    rdy = 0;
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("stall.f", 32'(f8), 32'hA);
      chk("stall.ch", 32'(ch8), 32'd2);
      chk("stall.valid", 32'(v8), 32'd1);
    end
    rst = 1; tick();
    chk("midrst.f", 32'(f8), 32'd0);
    chk("midrst.ch", 32'(ch8), 32'd0);
    chk("midrst.valid", 32'(v8), 32'd0);
    drive(0, 1, 3'd0, 8'hFF, WA, 1); tick();
    chk("midrst.ptr0_ch", 32'(ch8), 32'd0);
    chk("midrst.ptr0_f", 32'(f8), 32'h8);

    // mode switch: scan to ch2, direct for two cycles, scan resumes at 3
    drive(1, 1, 3'd0, 8'hFF, WA, 1); tick();
    rst = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("msw.scan%0d", k), 32'(ch8), 32'(k));
    end
    mode = 0; sel = 3'd6;
    tick();
    chk("msw.direct_ch", 32'(ch8), 32'd6);
    chk("msw.direct_f", 32'(f8), 32'hE);
    tick();
    mode = 1;
    tick();
    chk("msw.resume_ch", 32'(ch8), 32'd3);
    chk("msw.resume_f", 32'(f8), 32'hB);

    // randomized traffic against the reference model
    m8 = '{0, 0, 0, 0};
    m6 = '{0, 0, 0, 0};
    for (int k = 0; k < 400; k++) begin
      rst = (k == 0) || ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 7) == 0) mode = ~mode;
      sel = 3'($urandom);
      req = ($urandom_range(0, 1) == 0) ? 8'($urandom) : 8'($urandom & $urandom);
      w   = $urandom;
      rdy = ($urandom_range(0, 3) != 0);
      tick();
      m8 = step(m8, 8, rst, mode, int'(sel), req, w, rdy);
      m6 = step(m6, 6, rst, mode, int'(sel), req, w, rdy);
      chk($sformatf("rnd%0d.f8", k), 32'(f8), 32'(m8.f));
      chk($sformatf("rnd%0d.ch8", k), 32'(ch8), 32'(m8.ch));
      chk($sformatf("rnd%0d.v8", k), 32'(v8), 32'(m8.vld));
      chk($sformatf("rnd%0d.f6", k), 32'(f6), 32'(m6.f));
      chk($sformatf("rnd%0d.ch6", k), 32'(ch6), 32'(m6.ch));
      chk($sformatf("rnd%0d.v6", k), 32'(v6), 32'(m6.vld));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
